// File: rtl/pdm_pkg.sv
// Shared types and constants for the PDM modulator family.
// The dither LFSR helper is used only when MULTICHANNEL_PDM_DITHER_EN is defined.
package pdm_pkg;

  localparam int          PDM_CH_MAX    = 8;
  localparam logic [15:0] PDM_LFSR_SEED = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1, taps at bits 15, 13, 12 and 10
  localparam logic [15:0] PDM_LFSR_TAPS = 16'hB400;

  typedef logic [2:0] pdm_slot_t;

  typedef enum logic {
    ST_ARM,
    ST_RUN
  } pdm_state_t;

  function automatic logic [15:0] pdm_lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & PDM_LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pdm_edge_sync.sv
// Two-flop synchroniser for the PDM bit clock plus a delay flop.
// Produces single-cycle rise, fall and toggle strobes in the clk domain.
module pdm_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic ock,
  output logic rise,
  output logic fall,
  output logic toggle
);

  logic s1;
  logic s2;
  logic d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      d  <= 1'b0;
    end else begin
      s1 <= ock;
      s2 <= s1;
      d  <= s2;
    end
  end

  assign toggle = s2 ^ d;
  assign rise   = s2 & ~d;
  assign fall   = ~s2 & d;

endmodule

// File: rtl/multichannel_pdm_modulator.sv
// N-channel first-order PDM modulator time-multiplexed on one serial line.
// Optional LFSR dither is compiled in with MULTICHANNEL_PDM_DITHER_EN.
module multichannel_pdm_modulator
  import pdm_pkg::*;
#(
  parameter int DW = 32,
  parameter int CH = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           ock,
  input  logic [CH*DW-1:0] din,
  input  logic           din_vld,
  output logic           din_rdy,
  output logic           frame,
  output logic           urun,
  input  logic           urun_clr,
  output logic           sdo
);

  logic             rise;
  logic             fall;
  logic             toggle;
  pdm_state_t       state;
  pdm_state_t       state_n;
  logic             step;
  logic             serve0;
  pdm_slot_t        slot;
  logic             full;
  logic             seen;
  logic [CH*DW-1:0] hold;
  logic [CH*DW-1:0] work;
  logic [CH*DW-1:0] cur;
  logic [DW-1:0]    acc [CH];
  logic [DW-1:0]    acc_sel;
  logic [DW-1:0]    sample;
  logic [DW:0]      sum;
  logic             sdo_r;
  logic             urun_set;

  pdm_edge_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .ock    (ock),
    .rise   (rise),
    .fall   (fall),
    .toggle (toggle)
  );

  // ST_ARM waits for the first rising edge (slot 0); falling edges are dropped there.
  always_comb begin
    state_n = state;
    step    = 1'b0;
    if (!en) begin
      state_n = ST_ARM;
    end else if (state == ST_ARM) begin
      step = toggle & ~fall;
      if (step) state_n = ST_RUN;
    end else begin
      step = (CH == 1) ? rise : toggle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_ARM;
    else     state <= state_n;
  end

  assign serve0   = step & (slot == '0);
  assign cur      = (slot == '0 && full) ? hold : work;
  assign urun_set = serve0 & ~full & seen;

  always_comb begin
    sample  = '0;
    acc_sel = '0;
    for (int c = 0; c < CH; c++) begin
      if (slot == pdm_slot_t'(c)) begin
        sample  = cur[c*DW +: DW];
        acc_sel = acc[c];
      end
    end
  end

`ifdef MULTICHANNEL_PDM_DITHER_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       lfsr <= PDM_LFSR_SEED;
    else if (step) lfsr <= pdm_lfsr_next(lfsr);
  end

  assign sum = {1'b0, acc_sel} + {1'b0, sample} + {{(DW-7){1'b0}}, lfsr[7:0]};
`else
  assign sum = {1'b0, acc_sel} + {1'b0, sample};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
    end else if (!en) begin
      slot <= '0;
    end else if (step) begin
      slot <= (slot == pdm_slot_t'(CH-1)) ? '0 : slot + 3'd1;
    end
  end

  // Handshake: a frame transfers on a cycle where din_vld and din_rdy are both high;
  // while din_rdy is low the source must keep din stable with din_vld asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      seen <= 1'b0;
      hold <= '0;
      work <= '0;
    end else begin
      if (din_vld && !full) begin
        hold <= din;
        full <= 1'b1;
        seen <= 1'b1;
      end else if (serve0 && full) begin
        work <= hold;
        full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) acc[c] <= '0;
    end else if (step) begin
      for (int c = 0; c < CH; c++) begin
        if (slot == pdm_slot_t'(c)) acc[c] <= sum[DW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       sdo_r <= 1'b0;
    else if (!en)  sdo_r <= 1'b0;
    else if (step) sdo_r <= sum[DW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           urun <= 1'b0;
    else if (urun_set) urun <= 1'b1;
    else if (urun_clr) urun <= 1'b0;
  end

  assign din_rdy = ~full;
  assign frame   = serve0;
  // Gating by en makes the line drop the same cycle the modulator is disabled.
  assign sdo     = sdo_r & en;

endmodule
